// File: rtl/uart_bus_master_pkg.sv
// Shared opcode/response byte constants and FSM state encoding for the UART bus master.
package uart_bus_master_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_HALT  = 8'h48;
  localparam logic [7:0] OP_GO    = 8'h47;

  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_DATA = 8'h44;
  localparam logic [7:0] RSP_ERR  = 8'h45;
  localparam logic [7:0] RSP_UNK  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_ISSUE,
    S_SAMPLE,
    S_RESP
  } state_t;

  // Single-byte responses sit in the top byte of the 5-byte response buffer.
  function automatic logic [39:0] resp1(input logic [7:0] b);
    return {b, 32'h0};
  endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// Byte streams to/from the uart core plus the port-b bus seen by the bridge.
interface uart_bus_master_if;
  // Stream handshake: a byte transfers on a rising clk edge where tvalid and
  // tready are both 1; tvalid/tdata stay stable until that edge.
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic        bus_req;
  logic        bus_grant;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_we;
  logic [31:0] bus_rdata;
  logic        bus_strobe;

  modport master (
    input  rx_tdata, rx_tvalid, tx_tready, bus_grant, bus_rdata, bus_strobe,
    output rx_tready, tx_tdata, tx_tvalid, bus_req, bus_addr, bus_wdata, bus_we
  );

  modport slave (
    output rx_tdata, rx_tvalid, tx_tready, bus_grant, bus_rdata, bus_strobe,
    input  rx_tready, tx_tdata, tx_tvalid, bus_req, bus_addr, bus_wdata, bus_we
  );
endinterface

// File: rtl/ubm_txq.sv
// Five-byte response buffer: loaded in one shot, drained MSB byte first over a
// valid/ready stream. tdata and tvalid come straight from flops.
module ubm_txq (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [39:0] load_data,
  input  logic [2:0]  load_len,
  output logic [7:0]  tdata,
  output logic        tvalid,
  input  logic        tready,
  output logic        last
);

  logic [39:0] sr;
  logic [2:0]  cnt;
  logic        pop;

  assign pop   = tvalid && tready;
  assign tdata = sr[39:32];
  assign last  = (cnt == 3'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr     <= '0;
      cnt    <= '0;
      tvalid <= 1'b0;
    end else if (load) begin
      sr     <= load_data;
      cnt    <= load_len;
      tvalid <= (load_len != 3'd0);
    end else if (pop) begin
      sr     <= {sr[31:0], 8'h00};
      cnt    <= cnt - 3'd1;
      tvalid <= (cnt != 3'd1);
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven port-b bus initiator: W/R commands in, K/D/E/? responses out.
// Optional halt control (H/G opcodes, cpu_halt port) under UART_BUS_MASTER_HALT_EN.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYC = 9_000_000,
  parameter int          TO_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  uart_bus_master_if.master bif,
  output state_t           state
`ifdef UART_BUS_MASTER_HALT_EN
  ,
  output logic             cpu_halt
`endif
);

  state_t      next;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        cmd_wr;
  logic [1:0]  byte_cnt;
  logic [TO_W-1:0] to_cnt;

  logic        accept;
  logic        timeout;
  logic        tx_pop;
  logic        txq_last;
  logic        txq_load;
  logic [39:0] txq_data;
  logic [2:0]  txq_len;
  logic [7:0]  rx_byte;
`ifdef UART_BUS_MASTER_HALT_EN
  logic        halt_set;
  logic        halt_clr;
`endif

  assign rx_byte = bif.rx_tdata;
  assign accept  = bif.rx_tvalid && bif.rx_tready;
  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign tx_pop  = bif.tx_tvalid && bif.tx_tready;

  ubm_txq u_txq (
    .clk       (clk),
    .rst       (rst),
    .load      (txq_load),
    .load_data (txq_data),
    .load_len  (txq_len),
    .tdata     (bif.tx_tdata),
    .tvalid    (bif.tx_tvalid),
    .tready    (bif.tx_tready),
    .last      (txq_last)
  );

  always_comb begin
    next     = state;
    txq_load = 1'b0;
    txq_data = '0;
    txq_len  = '0;
`ifdef UART_BUS_MASTER_HALT_EN
    halt_set = 1'b0;
    halt_clr = 1'b0;
`endif
    case (state)
      S_IDLE: if (accept) begin
        if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
          next = S_ADDR;
        end else begin
          next     = S_RESP;
          txq_load = 1'b1;
          txq_len  = 3'd1;
          txq_data = resp1(RSP_UNK);
`ifdef UART_BUS_MASTER_HALT_EN
          if (rx_byte == OP_HALT) begin
            halt_set = 1'b1;
            txq_data = resp1(RSP_OK);
          end else if (rx_byte == OP_GO) begin
            halt_clr = 1'b1;
            txq_data = resp1(RSP_OK);
          end
`endif
        end
      end
      S_ADDR: if (accept) begin
        if (byte_cnt == 2'd3) next = cmd_wr ? S_DATA : S_REQ;
      end else if (timeout) begin
        next = S_IDLE;
      end
      S_DATA: if (accept) begin
        if (byte_cnt == 2'd3) next = S_REQ;
      end else if (timeout) begin
        next = S_IDLE;
      end
      S_REQ:   if (bif.bus_grant) next = S_ISSUE;
      S_ISSUE: next = S_SAMPLE;
      S_SAMPLE: begin
        // Responders answer one cycle after ISSUE, so rdata/strobe are valid here.
        next     = S_RESP;
        txq_load = 1'b1;
        txq_len  = 3'd1;
        if (cmd_wr) begin
          txq_data = resp1(RSP_OK);
        end else if (bif.bus_strobe) begin
          txq_data = {RSP_DATA, bif.bus_rdata};
          txq_len  = 3'd5;
        end else begin
          txq_data = resp1(RSP_ERR);
        end
      end
      S_RESP: if (tx_pop && txq_last) next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      cmd_wr        <= 1'b0;
      byte_cnt      <= '0;
      to_cnt        <= '0;
      bif.rx_tready <= 1'b0;
      bif.bus_req   <= 1'b0;
      bif.bus_addr  <= IDLE_ADDR;
      bif.bus_wdata <= '0;
      bif.bus_we    <= '0;
    end else begin
      state <= next;
      if (accept) begin
        case (state)
          S_IDLE: begin
            cmd_wr   <= (rx_byte == OP_WRITE);
            byte_cnt <= '0;
          end
          S_ADDR: begin
            addr_q   <= {addr_q[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
          end
          S_DATA: begin
            data_q   <= {data_q[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
          end
          default: ;
        endcase
      end
      if ((state == S_ADDR || state == S_DATA) && !accept) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;
      // Outputs are registered from the next state so they line up with it.
      bif.rx_tready <= (next == S_IDLE) || (next == S_ADDR) || (next == S_DATA);
      bif.bus_req   <= (next == S_REQ) || (next == S_ISSUE) || (next == S_SAMPLE);
      bif.bus_addr  <= (next == S_ISSUE) ? addr_q : IDLE_ADDR;
      bif.bus_we    <= (next == S_ISSUE && cmd_wr) ? 32'd1 : 32'd0;
      bif.bus_wdata <= (next == S_ISSUE && cmd_wr) ? data_q : 32'd0;
    end
  end

`ifdef UART_BUS_MASTER_HALT_EN
  always_ff @(posedge clk) begin
    if (!rst)          cpu_halt <= 1'b0;
    else if (halt_set) cpu_halt <= 1'b1;
    else if (halt_clr) cpu_halt <= 1'b0;
  end
`endif

endmodule
